fp_result_collector: RTL and testbench

FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

---
 rtl/fp_result_collector.sv | 105 ++++++++++
 tb/tb_fp_result_collector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// rtl/fp_result_collector.sv - FWFT result FIFO for summator outputs with sticky overflow flag.
// Optional status event counters are built when FP_COLLECT_STATS_EN is defined.
module fp_result_collector #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       res_vld_i,
  input  logic [31:0]                res_i,
  input  logic [1:0]                 res_status_i,
  output logic                       afull_o,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [31:0]                out_res_o,
  output logic [1:0]                 out_status_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  input  logic                       ovf_clr_i
`ifdef FP_COLLECT_STATS_EN
  ,
  output logic [15:0]                zero_cnt_o,
  output logic [15:0]                inf_cnt_o,
  output logic [15:0]                nan_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [33:0]   w_head;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && out_rdy_i;
  assign w_push = res_vld_i && (!w_full || w_pop);
  assign w_drop = res_vld_i && w_full && !w_pop;
  assign w_head = r_mem[r_rptr];

  // Output is gated so the head reads as zero while empty, including after reset.
  assign out_vld_o    = (r_count != '0);
  assign out_res_o    = out_vld_o ? w_head[33:2] : 32'd0;
  assign out_status_o = out_vld_o ? w_head[1:0]  : 2'd0;
  assign count_o      = r_count;
  assign afull_o      = (r_count >= AFULL_CNT);
  assign ovf_o        = r_ovf;

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wptr] <= {res_i, res_status_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      // A fresh overflow outranks a clear issued in the same cycle.
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
    end
  end

`ifdef FP_COLLECT_STATS_EN
  logic [15:0] r_zero_cnt;
  logic [15:0] r_inf_cnt;
  logic [15:0] r_nan_cnt;

  // Every valid result is counted, even those dropped on overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zero_cnt <= '0;
      r_inf_cnt  <= '0;
      r_nan_cnt  <= '0;
    end else if (res_vld_i) begin
      if (res_status_i == 2'b01 && r_zero_cnt != 16'hFFFF) r_zero_cnt <= r_zero_cnt + 16'd1;
      if (res_status_i == 2'b10 && r_inf_cnt  != 16'hFFFF) r_inf_cnt  <= r_inf_cnt  + 16'd1;
      if (res_status_i == 2'b11 && r_nan_cnt  != 16'hFFFF) r_nan_cnt  <= r_nan_cnt  + 16'd1;
    end
  end

  assign zero_cnt_o = r_zero_cnt;
  assign inf_cnt_o  = r_inf_cnt;
  assign nan_cnt_o  = r_nan_cnt;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// tb/tb_fp_result_collector.sv - directed self-checking bench for fp_result_collector.
// Counter checks are included when FP_COLLECT_STATS_EN is defined.
module tb_fp_result_collector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        res_vld_i;
  logic [31:0] res_i;
  logic [1:0]  res_status_i;
  logic        afull_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic [31:0] out_res_o;
  logic [1:0]  out_status_o;
  logic [2:0]  count_o;
  logic        ovf_o;
  logic        ovf_clr_i;
`ifdef FP_COLLECT_STATS_EN
  logic [15:0] zero_cnt_o;
  logic [15:0] inf_cnt_o;
  logic [15:0] nan_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  fp_result_collector #(.DEPTH(4), .AFULL_LVL(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .res_vld_i    (res_vld_i),
    .res_i        (res_i),
    .res_status_i (res_status_i),
    .afull_o      (afull_o),
    .out_vld_o    (out_vld_o),
    .out_rdy_i    (out_rdy_i),
    .out_res_o    (out_res_o),
    .out_status_o (out_status_o),
    .count_o      (count_o),
    .ovf_o        (ovf_o),
    .ovf_clr_i    (ovf_clr_i)
`ifdef FP_COLLECT_STATS_EN
    ,
    .zero_cnt_o   (zero_cnt_o),
    .inf_cnt_o    (inf_cnt_o),
    .nan_cnt_o    (nan_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input logic [1:0] st);
    res_vld_i    = 1'b1;
    res_i        = v;
    res_status_i = st;
  endtask

  initial begin
    rst_i = 1'b1; res_vld_i = 1'b0; res_i = '0; res_status_i = '0;
    out_rdy_i = 1'b0; ovf_clr_i = 1'b0;
    tick(); tick();
    check("rst_vld",    32'(out_vld_o), 32'd0);
    check("rst_count",  32'(count_o), 32'd0);
    check("rst_afull",  32'(afull_o), 32'd0);
    check("rst_ovf",    32'(ovf_o), 32'd0);
    check("rst_res",    out_res_o, 32'd0);
    check("rst_status", 32'(out_status_o), 32'd0);

    // Streaming with consumer ready; first push on the edge reset deasserts.
    rst_i = 1'b0; out_rdy_i = 1'b1;
    push(32'h4044CCCD, 2'b00); tick();
    check("s0_vld", 32'(out_vld_o), 32'd1);
    check("s0_res", out_res_o, 32'h4044CCCD);
    check("s0_cnt", 32'(count_o), 32'd1);
    push(32'h40000000, 2'b00); tick();
    check("s1_res", out_res_o, 32'h40000000);
    check("s1_cnt", 32'(count_o), 32'd1);
    push(32'h3F800000, 2'b00); tick();
    check("s2_res", out_res_o, 32'h3F800000);
    check("s2_cnt", 32'(count_o), 32'd1);
    res_vld_i = 1'b0; tick();
    check("s_empty_vld", 32'(out_vld_o), 32'd0);
    check("s_empty_cnt", 32'(count_o), 32'd0);

    // Invalid data is ignored.
    res_i = 32'hDEADBEEF; res_status_i = 2'b11; tick();
    check("ign_cnt", 32'(count_o), 32'd0);

    // Fill with consumer stalled, then overflow.
    out_rdy_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(32'hA000_0000 + 32'(k), 2'b00); tick();
      check($sformatf("fill%0d_cnt", k), 32'(count_o), (k > 4) ? 32'd4 : 32'(k));
      check($sformatf("fill%0d_afull", k), 32'(afull_o), (k >= 2) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_head", k), out_res_o, 32'hA000_0001);
      check($sformatf("fill%0d_ovf", k), 32'(ovf_o), (k == 5) ? 32'd1 : 32'd0);
    end
    ovf_clr_i = 1'b1; tick();
    check("ovf_clr_race", 32'(ovf_o), 32'd1);
    res_vld_i = 1'b0; tick();
    check("ovf_clr", 32'(ovf_o), 32'd0);
    ovf_clr_i = 1'b0;

    // Full FIFO: simultaneous push and pop.
    push(32'hB000_0005, 2'b00); out_rdy_i = 1'b1; tick();
    res_vld_i = 1'b0;
    check("pp_cnt",  32'(count_o), 32'd4);
    check("pp_ovf",  32'(ovf_o), 32'd0);
    check("pp_head", out_res_o, 32'hA000_0002);
    tick(); check("dr0", out_res_o, 32'hA000_0003);
    tick(); check("dr1", out_res_o, 32'hA000_0004);
    tick(); check("dr2", out_res_o, 32'hB000_0005);
    tick(); check("dr_empty", 32'(out_vld_o), 32'd0);

    // Special status values.
    out_rdy_i = 1'b0;
    push(32'h00000000, 2'b01); tick();
    push(32'h7F800000, 2'b10); tick();
    res_vld_i = 1'b0;
    check("st0_res", out_res_o, 32'h00000000);
    check("st0_st",  32'(out_status_o), 32'd1);
    out_rdy_i = 1'b1; tick();
    check("st1_res", out_res_o, 32'h7F800000);
    check("st1_st",  32'(out_status_o), 32'd2);
`ifdef FP_COLLECT_STATS_EN
    check("zero_cnt", 32'(zero_cnt_o), 32'd1);
    check("inf_cnt",  32'(inf_cnt_o), 32'd1);
    check("nan_cnt",  32'(nan_cnt_o), 32'd0);
`endif
    tick();
    check("st_empty", 32'(count_o), 32'd0);

    // Reset mid-operation discards the queue; push during reset is ignored.
    out_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'hC000_0000 + 32'(k), 2'b11); tick();
    end
    check("pre_rst_cnt", 32'(count_o), 32'd3);
    rst_i = 1'b1; push(32'hC0FF_EE00, 2'b01); tick();
    rst_i = 1'b0; res_vld_i = 1'b0;
    check("mrst_vld", 32'(out_vld_o), 32'd0);
    check("mrst_cnt", 32'(count_o), 32'd0);
    check("mrst_ovf", 32'(ovf_o), 32'd0);
    check("mrst_res", out_res_o, 32'd0);
`ifdef FP_COLLECT_STATS_EN
    check("mrst_zero", 32'(zero_cnt_o), 32'd0);
    check("mrst_nan",  32'(nan_cnt_o), 32'd0);
`endif

    // Pointer wrap: 9 push/pop pairs on a half-full queue.
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      push(32'hE000_0000 + 32'(k), 2'b00); tick();
      exp_q.push_back(32'hE000_0000 + 32'(k));
    end
    out_rdy_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push(32'hF000_0000 + 32'(k), 2'b00);
      check($sformatf("wrap%0d_head", k), out_res_o, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'hF000_0000 + 32'(k));
      check($sformatf("wrap%0d_cnt", k), 32'(count_o), 32'd2);
    end
    res_vld_i = 1'b0;
    while (exp_q.size() > 0) begin
      check("wrap_drain", out_res_o, exp_q.pop_front());
      tick();
    end
    check("wrap_empty", 32'(out_vld_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
